// File: rtl/fir_stim_gen.sv
// fir_stim_gen: staircase stimulus source (ramp up, ramp down, sign-alternating steps) for the FIR filter input
module fir_stim_gen #(
  parameter int DW   = 4,
  parameter int MAG  = 7,
  parameter int HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ready,
  output logic signed [DW-1:0] dout,
  output logic                 valid,
  output logic                 busy,
  output logic [1:0]           phase,
  output logic                 done
);
  localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam logic signed [DW-1:0] one = DW'(1);
  localparam logic signed [DW-1:0] pmax = DW'(MAG);
  localparam logic signed [DW-1:0] nmax = -pmax;
  localparam logic signed [DW-1:0] down_last = nmax + one;
  typedef enum logic [2:0] {IDLE, UP, DOWN, ALT, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic neg;
  logic adv;
  assign adv = valid && ready && cnt == CW'(HOLD - 1);
  // in ALT, neg marks that dout currently shows -k; the next k is then 1 - dout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dout  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      phase <= 2'd0;
      done  <= 1'b0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (valid && ready) cnt <= adv ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= UP;
          dout  <= nmax;
          valid <= 1'b1;
          busy  <= 1'b1;
          phase <= 2'd1;
          cnt   <= '0;
        end
        UP: if (adv) begin
          if (dout == pmax) begin
            state <= DOWN;
            phase <= 2'd2;
          end else dout <= dout + one;
        end
        DOWN: if (adv) begin
          if (dout == down_last) begin
            state <= ALT;
            phase <= 2'd3;
            dout  <= nmax;
            neg   <= 1'b0;
          end else dout <= dout - one;
        end
        ALT: if (adv) begin
          if (!neg) begin
            dout <= -dout;
            neg  <= 1'b1;
          end else if (dout == nmax) begin
            state <= DONE;
            dout  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            phase <= 2'd0;
            done  <= 1'b1;
          end else begin
            dout <= one - dout;
            neg  <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_stim_gen.sv
// tb_fir_stim_gen: directed checks of the default stimulus sequence, stalls, ignored start, abort, restart and a small config
module tb_fir_stim_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1, start2 = 1'b0;
  logic signed [3:0] dout, dout2;
  logic valid, busy, done, valid2, busy2, done2;
  logic [1:0] phase, phase2;
  int n_cmp = 0, n_err = 0;
  int ev[236], ep[236];
  logic hold_start = 1'b0;
  always #5 clk = ~clk;
  fir_stim_gen dut (.clk(clk), .rst(rst), .start(start), .ready(ready), .dout(dout),
    .valid(valid), .busy(busy), .phase(phase), .done(done));
  fir_stim_gen #(.DW(4), .MAG(3), .HOLD(1)) dut2 (.clk(clk), .rst(rst), .start(start2),
    .ready(1'b1), .dout(dout2), .valid(valid2), .busy(busy2), .phase(phase2), .done(done2));
  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b (done,valid,busy,phase,dout) want %b", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] pk(input logic d, v, b, input logic [1:0] p, input int x);
    return {d, v, b, p, 4'(x)};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // expects the first sample already on the outputs
  task automatic run_seq(input int stall_at, input int start_at, input int abort_at);
    for (int i = 0; i < 236; i++) begin
      start = hold_start || i == start_at;
      if (i == abort_at) begin
        rst = 1'b1;
        step;
        chk("abort", {done, valid, busy, phase, dout}, 9'd0);
        rst = 1'b0;
        repeat (4) begin
          step;
          chk("post_abort", {done, valid, busy, phase, dout}, 9'd0);
        end
        return;
      end
      if (i == stall_at) begin
        ready = 1'b0;
        repeat (3) begin
          chk("stall", {done, valid, busy, phase, dout}, pk(0, 1, 1, 2'(ep[i]), ev[i]));
          step;
        end
        ready = 1'b1;
      end
      chk("smp", {done, valid, busy, phase, dout}, pk(0, 1, 1, 2'(ep[i]), ev[i]));
      step;
    end
    chk("done", {done, valid, busy, phase, dout}, pk(1, 0, 0, 0, 0));
  endtask
  task automatic go;
    start = 1'b1;
    step;
    start = hold_start;
  endtask
  initial begin
    int n = 0;
    int s3[27] = '{-3, -2, -1, 0, 1, 2, 3, 3, 2, 1, 0, -1, -2, -3, 3, -2, 2, -1, 1, 0, 0, 1, -1, 2, -2, 3, -3};
    for (int v = -7; v <= 7; v++) repeat (4) begin ev[n] = v; ep[n] = 1; n++; end
    for (int v = 7; v >= -6; v--) repeat (4) begin ev[n] = v; ep[n] = 2; n++; end
    for (int k = -7; k <= 7; k++) begin
      repeat (4) begin ev[n] = k; ep[n] = 3; n++; end
      repeat (4) begin ev[n] = -k; ep[n] = 3; n++; end
    end
    step;
    step;
    chk("reset", {done, valid, busy, phase, dout}, 9'd0);
    chk("reset2", {done2, valid2, busy2, phase2, dout2}, 9'd0);
    rst = 1'b0;
    step;
    chk("idle", {done, valid, busy, phase, dout}, 9'd0);
    go;
    run_seq(-1, -1, -1);
    step;
    chk("after_done", {done, valid, busy, phase, dout}, 9'd0);
    go;
    run_seq(10, 49, -1);
    step;
    go;
    run_seq(-1, -1, 119);
    go;
    chk("restart", {done, valid, busy, phase, dout}, pk(0, 1, 1, 1, -7));
    rst = 1'b1;
    step;
    rst = 1'b0;
    hold_start = 1'b1;
    go;
    run_seq(-1, -1, -1);
    step;
    chk("hold_idle", {done, valid, busy, phase, dout}, 9'd0);
    step;
    chk("hold_restart", {done, valid, busy, phase, dout}, pk(0, 1, 1, 1, -7));
    hold_start = 1'b0;
    start = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    start2 = 1'b1;
    step;
    start2 = 1'b0;
    for (int i = 0; i < 27; i++) begin
      chk("small", {done2, valid2, busy2, phase2, dout2},
          pk(0, 1, 1, i < 7 ? 2'd1 : i < 13 ? 2'd2 : 2'd3, s3[i]));
      step;
    end
    chk("small_done", {done2, valid2, busy2, phase2, dout2}, pk(1, 0, 0, 0, 0));
    step;
    chk("small_idle", {done2, valid2, busy2, phase2, dout2}, 9'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
